// File: rtl/muldiv_seq_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_seq_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_datapath_step.sv
// One iteration of the shift-add multiplier or restoring divider.
module muldiv_datapath_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_mode_i,
    input  logic [2*WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH:0]   acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH:0] sh;

    // Multiply: {carry, partial product, multiplier}; divide: {rem, quotient}
    always_comb begin
        sum   = acc_i[2*WIDTH:WIDTH] + {1'b0, opnd_i};
        sh    = {acc_i[2*WIDTH-1:0], 1'b0};
        trial = sh[2*WIDTH:WIDTH] - {1'b0, opnd_i};
        acc_o = acc_i;
        if (div_mode_i) begin
            acc_o = trial[WIDTH] ? sh : {trial, sh[WIDTH-1:1], 1'b1};
        end else if (acc_i[0]) begin
            acc_o = {1'b0, sum, acc_i[WIDTH-1:1]};
        end else begin
            acc_o = {1'b0, acc_i[2*WIDTH:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
module muldiv_seq_unit
    import muldiv_seq_unit_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH:0]   acc_q, acc_step;
    logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
    logic               is_div_q, neg_lo_q, neg_hi_q, dbz_q;

    logic               accept, is_signed, is_div, a_neg, b_neg;
    logic               dbz_req, last;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_abs, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        accept    = (state_q == ST_IDLE) && in_valid && !flush;
        is_signed = !op[0];
        is_div    = op[1];
        a_neg     = is_signed && a[WIDTH-1];
        b_neg     = is_signed && b[WIDTH-1];
        abs_a     = a_neg ? -a : a;
        abs_b     = b_neg ? -b : b;
        dbz_req   = is_div && (b == '0);
        last      = (cnt_q == CNT_W'(WIDTH - 1));
        prod_abs  = acc_q[2*WIDTH-1:0];
        prod_fix  = neg_lo_q ? -prod_abs : prod_abs;
        quo_fix   = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    muldiv_datapath_step #(.WIDTH(WIDTH)) u_step (
        .div_mode_i (is_div_q),
        .acc_i      (acc_q),
        .opnd_i     (opnd_q),
        .acc_o      (acc_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Flush outranks both iteration progress and the output handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = dbz_req ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (flush)     state_d = ST_IDLE;
                else if (last) state_d = ST_FIX;
            end
            ST_FIX:  state_d = flush ? ST_IDLE : ST_DONE;
            ST_DONE: if (flush || out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            if (accept) begin
                if (dbz_req) begin
                    hi_q  <= a;
                    lo_q  <= '1;
                    dbz_q <= 1'b1;
                end else begin
                    acc_q    <= {{(WIDTH + 1){1'b0}}, abs_a};
                    opnd_q   <= abs_b;
                    cnt_q    <= '0;
                    is_div_q <= is_div;
                    neg_lo_q <= a_neg ^ b_neg;
                    neg_hi_q <= a_neg;
                end
            end
            if (state_q == ST_RUN && !flush) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q == ST_FIX && !flush) begin
                hi_q  <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
                lo_q  <= is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
                dbz_q <= 1'b0;
            end
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Randomized self-checking bench for muldiv_seq_unit against a 64-bit arithmetic model.
module tb_muldiv_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n, flush, in_valid, out_ready;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, div_by_zero, busy;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] prev_h, prev_l;
    logic         prev_z;

    muldiv_seq_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y,
                                  output logic [W-1:0] h,
                                  output logic [W-1:0] l,
                                  output logic z);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        z  = 1'b0;
        h  = '0;
        l  = '0;
        case (o)
            2'b00: begin
                p = 64'(sx * sy);
                h = p[63:32];
                l = p[31:0];
            end
            2'b01: begin
                p = {32'b0, x} * {32'b0, y};
                h = p[63:32];
                l = p[31:0];
            end
            default: begin
                if (y == '0) begin
                    h = x;
                    l = '1;
                    z = 1'b1;
                end else if (o == 2'b10) begin
                    q = sx / sy;
                    r = sx % sy;
                    l = q[31:0];
                    h = r[31:0];
                end else begin
                    l = x / y;
                    h = x % y;
                end
            end
        endcase
    endfunction

    task automatic start(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(negedge clk);
        check("in_ready_before_req", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int lat_exp, input string tag);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 200);
        check({tag, "_latency"}, 64'(cyc), 64'(lat_exp));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", 64'(out_valid), 64'd0);
    endtask

    task automatic run_one(input logic [1:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input string tag);
        logic [W-1:0] eh, el;
        logic         ez;
        model(o, x, y, eh, el, ez);
        start(o, x, y);
        wait_done(ez ? 1 : W + 2, tag);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
        handshake();
        prev_h = eh;
        prev_l = el;
        prev_z = ez;
    endtask

    initial begin
        logic [W-1:0] eh, el, x, y;
        logic         ez;
        logic [1:0]   o;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 2'b00;
        a         = '0;
        b         = '0;
        #12;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        run_one(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
        check("mult_neg3x5_hi_const", 64'(hi), 64'hFFFF_FFFF);
        check("mult_neg3x5_lo_const", 64'(lo), 64'hFFFF_FFF1);
        run_one(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo_const", 64'(lo), 64'h0000_0001);
        run_one(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        check("div_neg7by2_lo_const", 64'(lo), 64'hFFFF_FFFD);
        check("div_neg7by2_hi_const", 64'(hi), 64'hFFFF_FFFF);
        run_one(2'b11, 32'd100, 32'd7, "divu_100by7");
        check("divu_100by7_lo_const", 64'(lo), 64'h0000_000E);
        check("divu_100by7_hi_const", 64'(hi), 64'h0000_0002);
        run_one(2'b11, 32'h12, 32'd0, "divu_by0");
        check("divu_by0_dbz_const", 64'(div_by_zero), 64'd1);
        run_one(2'b01, 32'd2, 32'd3, "multu_after_dbz");
        check("multu_after_dbz_lo_const", 64'(lo), 64'd6);
        run_one(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        check("div_overflow_lo_const", 64'(lo), 64'h8000_0000);
        run_one(2'b10, 32'h8000_0000, 32'd0, "div_by0_signed");

        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       y = '0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            run_one(o, x, y, "rand");
        end

        // Backpressure: results stay put and no new request sneaks in
        model(2'b00, 32'd11, 32'hFFFF_FFF0, eh, el, ez);
        start(2'b00, 32'd11, 32'hFFFF_FFF0);
        wait_done(W + 2, "bp");
        in_valid = 1'b1;
        op       = 2'b01;
        a        = 32'd7;
        b        = 32'd9;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hi", 64'(hi), 64'(eh));
            check("bp_lo", 64'(lo), 64'(el));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_hs_out_valid", 64'(out_valid), 64'd0);
        check("bp_hs_busy", 64'(busy), 64'd0);
        check("bp_hs_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done(W + 2, "bp_next");
        check("bp_next_lo", 64'(lo), 64'd63);
        check("bp_next_hi", 64'(hi), 64'd0);
        handshake();
        prev_h = 32'd0;
        prev_l = 32'd63;
        prev_z = 1'b0;

        // Flush mid-RUN keeps the previous result
        start(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_run_busy", 64'(busy), 64'd0);
        check("flush_run_in_ready", 64'(in_ready), 64'd1);
        check("flush_run_out_valid", 64'(out_valid), 64'd0);
        check("flush_run_hi", 64'(hi), 64'(prev_h));
        check("flush_run_lo", 64'(lo), 64'(prev_l));
        check("flush_run_dbz", 64'(div_by_zero), 64'(prev_z));

        // Flush in IDLE blocks a simultaneous request
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        op       = 2'b01;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);

        // Flush in DONE drops out_valid but keeps the loaded result
        model(2'b11, 32'd1000, 32'd33, eh, el, ez);
        start(2'b11, 32'd1000, 32'd33);
        wait_done(W + 2, "flush_done");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_out_valid", 64'(out_valid), 64'd0);
        check("flush_done_lo", 64'(lo), 64'(el));
        check("flush_done_hi", 64'(hi), 64'(eh));

        // Asynchronous reset mid-RUN
        start(2'b00, 32'hDEAD_BEEF, 32'h0000_0777);
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_busy_after", 64'(busy), 64'd0);

        run_one(2'b10, 32'd77, 32'hFFFF_FFF6, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_seq_unit.md
Name: muldiv_seq_unit

Overview:
- Parametrised iterative multiply/divide unit that extends the single-cycle ALU with MULT, MULTU, DIV and DIVU.
- Computes one result bit per clock: shift-add for multiply, restoring for divide.
- Writes a double-width result into HI/LO registers.
- Sits beside the ALU in the execute path. Valid/ready handshakes on both sides let the control unit stall while it is busy.

Parameters:
- WIDTH, 32, operand width in bits; legal range is 4 or more.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort of an in-flight operation
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept a request
- op  input  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- a  input  WIDTH  multiplicand / dividend
- b  input  WIDTH  multiplier / divisor
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- hi  output  WIDTH  upper product / remainder
- lo  output  WIDTH  lower product / quotient
- div_by_zero  output  1  last completed op was a divide with b==0
- busy  output  1  state is not IDLE

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; hi=0, lo=0; out_valid=0, div_by_zero=0, busy=0, in_ready=1.
  - Internal accumulator and counter are cleared.
  - Reset asserted in any state aborts the operation immediately.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, the unit latches op and the operand magnitudes.
  - Signed ops take absolute values, with negation modulo 2^WIDTH, and record the result signs:
    - product sign = a_msb ^ b_msb;
    - quotient sign = a_msb ^ b_msb;
    - remainder sign = a_msb.
  - Next state is RUN with counter=0.
  - Exception: a divide with b==0 goes directly to DONE with div_by_zero=1, hi=a unmodified, lo=all ones.
- RUN:
  - Exactly WIDTH cycles; one iteration per edge; counter increments each edge.
  - Transition to FIX on the edge where counter==WIDTH-1.
  - Multiply: 2*WIDTH-bit accumulator; conditional add of the multiplicand, then right shift.
  - Divide: shift the remainder left, trial-subtract the divisor, set the quotient bit when the result is non-negative.
- FIX:
  - One cycle.
  - Apply two's-complement negation per the recorded signs (signed ops only).
  - Load hi and lo.
  - Transition to DONE.
- DONE:
  - out_valid=1; hi and lo stable.
  - On out_ready, go to IDLE; out_valid drops on the same edge.
- Latency:
  - Normal op: out_valid is first high WIDTH+2 cycles after the acceptance cycle.
  - Divide-by-zero: out_valid is high the cycle after acceptance.
- in_ready=0 in RUN, FIX and DONE. A new request is never accepted in the same cycle as the out handshake.
- hi and lo hold the last result after the handshake until the next FIX or divide-by-zero load. div_by_zero is updated at every completion.
- Signed overflow case, DIV of most-negative by -1: lo=most-negative, hi=0, no flag.
- Flush:
  - In RUN or FIX, flush=1 returns the unit to IDLE on the next edge.
  - hi, lo and div_by_zero are unchanged.
  - Flush in DONE also drops out_valid.
  - Flush in IDLE is ignored, and a simultaneous in_valid is not accepted.
  - Flush has priority over the out_ready handshake.
- Width rules:
  - All arithmetic is modulo 2^WIDTH per half; the accumulator is 2*WIDTH+1 bits to hold the trial-subtract borrow.
  - The counter saturates at no point; it is cleared on entering RUN.

Decomposition:
- Shared package holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the FSM state encodings.
- One natural sub-module, muldiv_datapath_step: combinational single-iteration step (add-shift or trial-subtract) driven by a mode bit.
- The top level owns the FSM, counter, sign bookkeeping and the HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; out_valid rises exactly 34 cycles after acceptance.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; div_by_zero=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=0x0000000E, hi=0x00000002.
- DIVU a=0x12, b=0:
  - required response: div_by_zero=1, hi=0x12, lo=0xFFFFFFFF; out_valid high the cycle after acceptance.
  - a following MULTU 2*3 must clear div_by_zero and give lo=6.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 throughout -> out_valid, hi and lo stable; in_ready=0; the next op is accepted only after the handshake cycle.
- Abort cases:
  - flush at RUN cycle 10 -> IDLE next cycle; hi and lo keep the prior result.
  - reset_n pulsed low mid-RUN -> all outputs zero asynchronously and in_ready=1 after release.
